psum_drain: RTL and testbench
=============================

# psum_drain

Output-side reader for the accelerator's packed partial-sum bus. It accepts whole `col*bw_psum` psum rows from the core through a valid/ready handshake and buffers them in a small row FIFO. It then streams each row one column per beat over a `bw_psum`-wide valid/ready port, applying optional per-row ReLU. It sits between the core's `out` bus and the off-chip/SRAM writeback path.

## Interface
- `col`, default 8: columns per psum row.
- `bw_psum`, default 20: width of one column's partial sum, two's complement.
- `depth`, default 2: row FIFO entries; power of two, ≥2.
- `clk`  input  1  single clock, all state on rising edge.
- `reset`  input  1  asynchronous, active-low reset; clears all state immediately when low.
- `in_data`  input  col*bw_psum  packed row; column c occupies bits [c*bw_psum +: bw_psum].
- `in_relu`  input  1  ReLU enable for this row, captured with `in_data`.
- `in_valid`  input  1  row present.
- `in_ready`  output  1  FIFO can accept a row.
- `out_data`  output  bw_psum  current column value.
- `out_col`  output  $clog2(col)  index of current column.
- `out_last`  output  1  current beat is column col-1.
- `out_valid`  output  1  beat present.
- `out_ready`  input  1  downstream accepts beat.
- `row_cnt`  output  8  rows fully drained, modulo 256.

## Operation
- Storage: `depth` entries of {relu flag, row}; write pointer, read pointer, occupancy count 0..depth.
- Push: `in_valid && in_ready` at a rising edge writes the entry and increments the write pointer and count.
- `in_ready = (count != depth)`. It is never raised by a same-cycle pop, so there is no bypass when full.
- Read side: `out_valid = (count != 0)`. The head entry is presented at column `col_idx` (register, 0..col-1).
- `out_data` = head column `col_idx`, after ReLU. If the head's relu flag is 1 and the column MSB is 1, `out_data` = 0; otherwise it is the raw value.
- `out_data` = 0 and `out_last` = 0 whenever `out_valid` = 0.
- `out_col = col_idx`; `out_last = out_valid && (col_idx == col-1)`.
- Beat accepted (`out_valid && out_ready`):
  - If not last, `col_idx` increments.
  - If last, `col_idx` goes to 0, the read pointer advances, count decrements, and `row_cnt` increments, wrapping 255→0.
- Simultaneous push and last-beat pop in one edge: count is unchanged and both pointers advance.
- `out_ready` low holds `out_data`, `out_col`, and `out_valid` stable. Once asserted, `out_valid` does not drop until the beat is accepted.
- Pointers wrap modulo `depth`.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_col`=0, `out_last`=0, `row_cnt`=0, `in_ready`=1.
- While `reset` is low, no push is accepted.
- Reset low mid-row discards all buffered rows and the partial column position. After release, the first accepted row streams from column 0.
- Latency: a row pushed at edge N gives `out_valid`=1, column 0, in the cycle after edge N. No combinational path exists from `in_*` to `out_*`.
- Throughput: one column per cycle with `out_ready` held high. A row drains in `col` cycles.
- `in_ready` depends only on registered count. There is no combinational path from `out_ready` to `in_ready`.
- `out_valid`, `out_col`, and `out_last` are functions of registers only, plus `out_data` mux and ReLU logic.

## Test plan
- Single row, `out_ready`=1, `in_relu`=0, column c = c+1:
  - beats 1..8 appear on consecutive cycles starting one cycle after the push;
  - `out_last` is high only on col 7;
  - `row_cnt` goes 0→1.
- ReLU: row with col0=20'hFFFFF (−1), col1=20'h00005, col2=20'h80000, `in_relu`=1:
  - outputs are 0, 5, 0;
  - the same row with `in_relu`=0 outputs FFFFF, 00005, 80000.
- Backpressure: `out_ready` toggles 1,0,0,1 during a row:
  - `out_data`/`out_col` hold during the low cycles;
  - no column is skipped or repeated.
- Full: push 2 rows with `out_ready`=0:
  - `in_ready` goes 0 after the 2nd push;
  - a 3rd `in_valid` is not accepted;
  - on the edge that pops the last beat of row 0, `in_ready` is still 0 that cycle and becomes 1 the next.
- Wrap: stream 260 rows back-to-back, pushing on each last-beat pop:
  - `row_cnt` reads 4 at the end;
  - data order is preserved across pointer wrap.
- Reset mid-row: assert `reset` low at column 3 of row 0 with row 1 buffered:
  - outputs drop to reset values asynchronously;
  - after release, `out_valid`=0 until a new push, whose first beat is col 0.

Source files
------------

// File: rtl/psum_drain.sv
// psum_drain
//   Output-side reader for the packed partial-sum bus. Whole psum rows are
//   accepted from the core into a small row FIFO. Each row is then streamed
//   one column per beat, with optional per-row ReLU applied on the way out.
//
// Parameters
//   col      columns per psum row
//   bw_psum  width of one column's partial sum (two's complement)
//   depth    row FIFO entries (power of two, >= 2)
//
// Ports
//   clk        single clock, all state updates on the rising edge
//   reset      asynchronous active-low reset, clears all state
//   in_data    packed row, column c at [c*bw_psum +: bw_psum]
//   in_relu    ReLU enable for this row, stored alongside in_data
//   in_valid   row present
//   in_ready   FIFO has a free entry
//   out_data   current column value after optional ReLU (0 when idle)
//   out_col    index of the current column
//   out_last   current beat carries column col-1
//   out_valid  beat present
//   out_ready  downstream accepts beat
//   row_cnt    rows fully drained, modulo 256
//
// Handshake: a transfer happens on a rising edge where valid && ready.
// A source that raises valid keeps it, and its payload, stable until that
// transfer. Ready depends only on registered state on both ports, so there
// is no combinational path from one port to the other.

module psum_drain #(
   parameter int col     = 8,
   parameter int bw_psum = 20,
   parameter int depth   = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [col*bw_psum-1:0]   in_data,
   input  logic                     in_relu,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic [bw_psum-1:0]       out_data,
   output logic [$clog2(col)-1:0]   out_col,
   output logic                     out_last,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [7:0]               row_cnt
);

   localparam int cw = $clog2(col);
   localparam int pw = $clog2(depth);
   localparam int nw = $clog2(depth + 1);
   localparam logic [cw-1:0] last_col = cw'(col - 1);
   localparam logic [nw-1:0] full_cnt = nw'(depth);

   // Row storage: payload and its relu flag, written at the write pointer.
   logic [col*bw_psum-1:0] mem_row [depth];
   logic [depth-1:0]       mem_relu;

   logic [pw-1:0]      wr_ptr;
   logic [pw-1:0]      rd_ptr;
   logic [nw-1:0]      count;
   logic [cw-1:0]      col_idx;

   logic [bw_psum-1:0] head_col;
   logic               head_relu;
   logic               push;
   logic               beat;
   logic               pop;

   // Full/empty come straight from the registered count; a pop in the same
   // cycle does not open a slot, which keeps out_ready off the in_ready path.
   assign in_ready  = (count != full_cnt);
   assign out_valid = (count != '0);

   assign push = in_valid && in_ready;
   assign beat = out_valid && out_ready;
   assign pop  = beat && out_last;

   // Column select as a plain mux over the head row.
   always_comb begin
      head_col = '0;
      for (int c = 0; c < col; c++) begin
         if (col_idx == cw'(c)) begin
            head_col = mem_row[rd_ptr][c*bw_psum +: bw_psum];
         end
      end
   end

   assign head_relu = mem_relu[rd_ptr];

   // Negative columns of a relu row are clamped to zero; idle output is zero.
   assign out_data = (out_valid && !(head_relu && head_col[bw_psum-1])) ? head_col : '0;
   assign out_col  = col_idx;
   assign out_last = out_valid && (col_idx == last_col);

   // Storage needs no reset: nothing is read while count is zero.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_row[wr_ptr]  <= in_data;
         mem_relu[wr_ptr] <= in_relu;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         col_idx <= '0;
         row_cnt <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + pw'(1);
         end
         if (beat) begin
            if (out_last) begin
               col_idx <= '0;
               rd_ptr  <= rd_ptr + pw'(1);
               row_cnt <= row_cnt + 8'd1;
            end else begin
               col_idx <= col_idx + cw'(1);
            end
         end
         // Push and last-beat pop together leave the occupancy unchanged.
         case ({push, pop})
            2'b10:   count <= count + nw'(1);
            2'b01:   count <= count - nw'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_psum_drain.sv
// tb_psum_drain
//   Self-checking bench for psum_drain. Rows are pushed through a driver
//   task that also queues the expected beats; a negedge monitor pops and
//   compares every accepted output beat and checks hold-while-stalled.

module tb_psum_drain;

   localparam int col   = 8;
   localparam int bw    = 20;
   localparam int depth = 2;
   localparam int cw    = $clog2(col);

   logic              clk = 1'b0;
   logic              reset;
   logic [col*bw-1:0] in_data;
   logic              in_relu;
   logic              in_valid;
   logic              in_ready;
   logic [bw-1:0]     out_data;
   logic [cw-1:0]     out_col;
   logic              out_last;
   logic              out_valid;
   logic              out_ready;
   logic [7:0]        row_cnt;

   // Scoreboard entry: {last, col, data}
   logic [bw+cw:0]    exp_q[$];
   logic [bw+cw:0]    mon_e;
   int                exp_rows = 0;
   int                total = 0;
   int                bad = 0;
   logic              stall_q = 1'b0;
   logic [bw-1:0]     hold_data = '0;
   logic [cw-1:0]     hold_col = '0;
   logic [col*bw-1:0] row_v;
   bit                pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
   bit                found;

   psum_drain #(.col(col), .bw_psum(bw), .depth(depth)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_data   (in_data),
      .in_relu   (in_relu),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_col   (out_col),
      .out_last  (out_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .row_cnt   (row_cnt)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [bw-1:0] relu_model(input logic [bw-1:0] d, input logic r);
      return (r && d[bw-1]) ? '0 : d;
   endfunction

   function automatic logic [col*bw-1:0] rand_row();
      logic [col*bw-1:0] r;
      for (int c = 0; c < col; c++) r[c*bw +: bw] = bw'($urandom());
      return r;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic push_row(input logic [col*bw-1:0] row, input logic relu);
      bit ok = 1'b0;
      logic [bw+cw:0] e;
      @(posedge clk);
      #1;
      in_data  = row;
      in_relu  = relu;
      in_valid = 1'b1;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk);
      end
      if (ok) begin
         for (int c = 0; c < col; c++) begin
            e = {(c == col - 1) ? 1'b1 : 1'b0, cw'(c), relu_model(row[c*bw +: bw], relu)};
            exp_q.push_back(e);
         end
      end else begin
         check("push_timeout", 32'(in_ready), 32'd1);
      end
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_empty(input int limit);
      for (int i = 0; i < limit && exp_q.size() != 0; i++) @(negedge clk);
      check("drain_done", 32'(exp_q.size()), 32'd0);
      @(negedge clk);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_data"},  32'(out_data),  32'd0);
      check({tag, "_col"},   32'(out_col),   32'd0);
      check({tag, "_last"},  32'(out_last),  32'd0);
      check({tag, "_rowcnt"}, 32'(row_cnt),  32'd0);
      check({tag, "_inrdy"}, 32'(in_ready),  32'd1);
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      if (!reset) begin
         stall_q  <= 1'b0;
         exp_rows <= 0;
         exp_q.delete();
      end else begin
         if (stall_q) begin
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_data",  32'(out_data),  32'(hold_data));
            check("hold_col",   32'(out_col),   32'(hold_col));
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("beat_expected", 32'(out_valid), 32'd0);
            end else begin
               mon_e = exp_q.pop_front();
               check("beat_data", 32'(out_data), 32'(mon_e[bw-1:0]));
               check("beat_col",  32'(out_col),  32'(mon_e[bw+cw-1:bw]));
               check("beat_last", 32'(out_last), 32'(mon_e[bw+cw]));
               if (mon_e[bw+cw]) exp_rows <= exp_rows + 1;
            end
         end else if (!out_valid) begin
            check("idle_data", 32'(out_data), 32'd0);
            check("idle_last", 32'(out_last), 32'd0);
         end
         stall_q   <= out_valid && !out_ready;
         hold_data <= out_data;
         hold_col  <= out_col;
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      reset     = 1'b0;
      in_data   = '0;
      in_relu   = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      #2;
      check_reset_values("rst");
      repeat (3) @(negedge clk);
      reset = 1'b1;

      // Single row, column c = c+1, full-rate drain.
      out_ready = 1'b1;
      for (int c = 0; c < col; c++) row_v[c*bw +: bw] = bw'(c + 1);
      push_row(row_v, 1'b0);
      @(negedge clk);
      check("lat_valid", 32'(out_valid), 32'd1);
      check("lat_col",   32'(out_col),   32'd0);
      for (int i = 1; i < col; i++) begin
         @(negedge clk);
         check("stream_valid", 32'(out_valid), 32'd1);
      end
      @(negedge clk);
      check("stream_end", 32'(out_valid), 32'd0);
      check("row_cnt_1", 32'(row_cnt), 32'd1);

      // ReLU on and off on the same row, then random rows.
      row_v = rand_row();
      row_v[0 +: bw]    = 20'hFFFFF;
      row_v[bw +: bw]   = 20'h00005;
      row_v[2*bw +: bw] = 20'h80000;
      push_row(row_v, 1'b1);
      push_row(row_v, 1'b0);
      for (int i = 0; i < 5; i++) push_row(rand_row(), 1'($urandom_range(0, 1)));
      wait_empty(200);

      // Backpressure pattern 1,0,0,1 during a row.
      push_row(rand_row(), 1'b0);
      for (int i = 0; i < 4; i++) begin
         out_ready = pat[i];
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      wait_empty(100);

      // Random backpressure while rows keep arriving.
      fork
         begin
            for (int i = 0; i < 4; i++) push_row(rand_row(), 1'($urandom_range(0, 1)));
         end
         begin
            for (int i = 0; i < 60; i++) begin
               @(posedge clk);
               #1;
               out_ready = 1'($urandom_range(0, 1));
            end
         end
      join
      out_ready = 1'b1;
      wait_empty(200);
      check("row_cnt_mid", 32'(row_cnt), 32'(exp_rows[7:0]));

      // Full FIFO: third row refused, in_ready reopens one cycle after the pop.
      out_ready = 1'b0;
      push_row(rand_row(), 1'b0);
      push_row(rand_row(), 1'b1);
      @(negedge clk);
      check("full_ready", 32'(in_ready), 32'd0);
      in_data  = rand_row();
      in_valid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("full_ready_hold", 32'(in_ready), 32'd0);
      end
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         found = out_last;
      end
      check("find_last", 32'(out_last), 32'd1);
      check("ready_at_pop", 32'(in_ready), 32'd0);
      @(negedge clk);
      check("ready_after_pop", 32'(in_ready), 32'd1);
      wait_empty(100);
      check("no_third_row", 32'(out_valid), 32'd0);

      // Wrap: 260 rows from a fresh reset, row_cnt ends at 4.
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      check("wrap_start_cnt", 32'(row_cnt), 32'd0);
      out_ready = 1'b1;
      for (int r = 0; r < 260; r++) push_row(rand_row(), 1'($urandom_range(0, 1)));
      wait_empty(200);
      check("wrap_row_cnt", 32'(row_cnt), 32'd4);
      check("wrap_row_model", 32'(row_cnt), 32'(exp_rows[7:0]));

      // Reset mid-row with a second row buffered.
      out_ready = 1'b0;
      push_row(rand_row(), 1'b0);
      push_row(rand_row(), 1'b0);
      out_ready = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         found = (out_col == cw'(3));
      end
      check("find_col3", 32'(out_col), 32'd3);
      #2;
      reset = 1'b0;
      #1;
      check_reset_values("async_rst");
      in_data  = rand_row();
      in_valid = 1'b1;
      repeat (2) @(negedge clk);
      in_valid = 1'b0;
      reset    = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("post_reset_idle", 32'(out_valid), 32'd0);
      end
      push_row(rand_row(), 1'b1);
      @(negedge clk);
      check("post_reset_valid", 32'(out_valid), 32'd1);
      check("post_reset_col",   32'(out_col),   32'd0);
      wait_empty(100);
      check("post_reset_rows", 32'(row_cnt), 32'd1);

      check("leftover", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
